// File: rtl/sqr_if.sv
// sqr_if: start/busy/ready handshake plus operand and result bus shared by the
// sqr squarer and the sqrt unit, so one controller can drive either.
//   start_i  master -> slave  request, sampled while the slave is idle
//   a_bi     master -> slave  operand, IN_W bits, unsigned
//   ready    slave -> master  1 = idle, able to accept start_i
//   busy_o   slave -> master  1 = computation in progress
//   y_bo     slave -> master  result, 2*IN_W bits, holds last completed value
interface sqr_if #(
    parameter int unsigned IN_W = 8
);
    localparam int unsigned OUT_W = 2 * IN_W;

    logic              start_i;
    logic [IN_W-1:0]   a_bi;
    logic              ready;
    logic              busy_o;
    logic [OUT_W-1:0]  y_bo;

    modport master (
        output start_i, a_bi,
        input  ready, busy_o, y_bo
    );

    modport slave (
        input  start_i, a_bi,
        output ready, busy_o, y_bo
    );
endinterface

// File: rtl/sqr.sv
// sqr: sequential shift-add squarer, y_bo = a_bi * a_bi, one multiplier bit
// per clock. Handshake-compatible with the sqrt unit.
// Ports:
//   clk_i   clock, all state updates on posedge
//   rst_i   synchronous active-high reset; aborts any operation in flight
//   bus     sqr_if.slave: start_i, a_bi in; ready, busy_o, y_bo out
// Parameters:
//   IN_W    operand width (>= 2); must match the IN_W of the connected sqr_if
// Build option:
//   SQR_EARLY_EXIT_EN  when defined, finish as soon as the remaining
//                      multiplier bits are all zero (latency tracks the
//                      operand's highest set bit, minimum one cycle)
module sqr #(
    parameter int unsigned IN_W = 8
) (
    input  logic  clk_i,
    input  logic  rst_i,
    sqr_if.slave  bus
);
    localparam int unsigned OUT_W = 2 * IN_W;
    localparam int unsigned CNT_W = $clog2(IN_W);

    typedef enum logic {
        S_IDLE,
        S_WORK
    } state_t;

    state_t            r_state;
    logic [OUT_W-1:0]  r_mcand;
    logic [IN_W-1:0]   r_mplier;
    logic [OUT_W-1:0]  r_acc;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_busy;
    logic              r_ready;
    logic [OUT_W-1:0]  r_y;

    logic [OUT_W-1:0]  w_acc_next;
    logic [IN_W-1:0]   w_mplier_next;
    logic              w_last;

    always_comb begin
        w_acc_next    = r_acc + (r_mplier[0] ? r_mcand : '0);
        w_mplier_next = r_mplier >> 1;
`ifdef SQR_EARLY_EXIT_EN
        // No set bits left to add: the accumulator is already final.
        w_last        = (r_cnt == CNT_W'(IN_W - 1)) || (w_mplier_next == '0);
`else
        w_last        = (r_cnt == CNT_W'(IN_W - 1));
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= S_IDLE;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_ready  <= 1'b1;
            r_y      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start_i) begin
                        r_mcand  <= OUT_W'(bus.a_bi);
                        r_mplier <= bus.a_bi;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_ready  <= 1'b0;
                        r_state  <= S_WORK;
                    end
                end
                S_WORK: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= w_mplier_next;
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_y     <= w_acc_next;
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.busy_o = r_busy;
    assign bus.ready  = r_ready;
    assign bus.y_bo   = r_y;
endmodule
